hamming_secded_decoder: RTL and testbench

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

---
 rtl/hamming_pkg.sv | 45 ++++
 rtl/hamming_syndrome.sv | 37 +++
 rtl/hamming_secded_decoder.sv | 160 ++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED decoder: codeword geometry, position classification
// and parity-mode encodings.
package hamming_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Smallest P with 2^P >= DATA_W + P + 1; scanning downward leaves the smallest match.
    function automatic int calc_p(input int data_w);
        int p;
        p = 0;
        for (int i = 7; i >= 1; i--) begin
            if ((1 << i) >= data_w + i + 1) begin
                p = i;
            end
        end
        return p;
    endfunction

    function automatic int calc_code_w(input int data_w);
        return data_w + calc_p(data_w) + 1;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position holding data bit k: the k-th non-power-of-two position from 3 up.
    function automatic int data_pos(input int k);
        int found;
        int cnt;
        found = -1;
        cnt   = 0;
        for (int pos = 3; pos < 128; pos++) begin
            if (!is_pow2(pos)) begin
                if (cnt == k && found < 0) begin
                    found = pos;
                end
                cnt++;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity check for one SECDED codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int P      = 3,
    parameter int CODE_W = 8
) (
    input  logic [CODE_W-1:0] code,
    input  logic              parity_type,
    output logic [P-1:0]      syndrome,
    output logic              overall
);

    logic par_inv;

    // Mask of every codeword position whose index has bit_i set.
    function automatic logic [CODE_W-1:0] group_mask(input int bit_i);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int pos = 0; pos < CODE_W; pos++) begin
            m[pos] = pos[bit_i];
        end
        return m;
    endfunction

    assign par_inv = (parity_type != PAR_EVEN);

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_syn
            localparam logic [CODE_W-1:0] MASK = group_mask(gi);
            assign syndrome[gi] = (^(code & MASK)) ^ par_inv;
        end
    endgenerate

    assign overall = (^code) ^ par_inv;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshakes and
// saturating corrected/uncorrected error counters.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  CNT_W  = 16,
    localparam int P      = calc_p(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    input  logic              parity_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              single_err,
    output logic              double_err,
    output logic [P:0]        err_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int PW = P + 1;

    logic              s1_valid_reg;
    logic [P-1:0]      s1_syn_reg;
    logic              s1_overall_reg;
    logic [DATA_W-1:0] s1_data_reg;
    logic [P-1:0]      syn_next;
    logic              overall_next;
    logic [DATA_W-1:0] s1_data_next;

    logic              out_valid_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              single_err_reg;
    logic              double_err_reg;
    logic [P:0]        err_pos_reg;
    logic [DATA_W-1:0] data_corr;
    logic              single_next;
    logic              double_next;
    logic [P:0]        err_pos_next;
    logic              flip;

    logic [CNT_W-1:0]  corr_cnt_reg;
    logic [CNT_W-1:0]  uncorr_cnt_reg;
    logic [CNT_W-1:0]  corr_cnt_next;
    logic [CNT_W-1:0]  uncorr_cnt_next;

    logic              s2_en;
    logic              deliver;

    hamming_syndrome #(
        .P      (P),
        .CODE_W (CODE_W)
    ) u_syndrome (
        .code        (code_in),
        .parity_type (parity_type),
        .syndrome    (syn_next),
        .overall     (overall_next)
    );

    // Parity positions are fully consumed by the syndrome, so only the raw data bits
    // travel down the pipe.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
            localparam int POS = data_pos(gi);
            assign s1_data_next[gi] = code_in[POS];
            assign data_corr[gi]    = s1_data_reg[gi] ^ (flip && (s1_syn_reg == P'(POS)));
        end
    endgenerate

    always_comb begin
        single_next  = 1'b0;
        double_next  = 1'b0;
        err_pos_next = '0;
        flip         = 1'b0;
        if (s1_overall_reg) begin
            // A syndrome pointing past the codeword cannot be a single flip.
            if ({1'b0, s1_syn_reg} > PW'(CODE_W - 1)) begin
                double_next = 1'b1;
            end else begin
                single_next  = 1'b1;
                flip         = 1'b1;
                err_pos_next = {1'b0, s1_syn_reg};
            end
        end else if (s1_syn_reg != '0) begin
            double_next = 1'b1;
        end
    end

    assign s2_en    = !out_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_en;
    assign deliver  = out_valid_reg && out_ready;

    always_comb begin
        corr_cnt_next   = corr_cnt_reg;
        uncorr_cnt_next = uncorr_cnt_reg;
        if (cnt_clr) begin
            corr_cnt_next   = '0;
            uncorr_cnt_next = '0;
        end else if (deliver) begin
            if (single_err_reg && (corr_cnt_reg != '1)) begin
                corr_cnt_next = corr_cnt_reg + 1'b1;
            end
            if (double_err_reg && (uncorr_cnt_reg != '1)) begin
                uncorr_cnt_next = uncorr_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_syn_reg     <= '0;
            s1_overall_reg <= 1'b0;
            s1_data_reg    <= '0;
            out_valid_reg  <= 1'b0;
            data_out_reg   <= '0;
            single_err_reg <= 1'b0;
            double_err_reg <= 1'b0;
            err_pos_reg    <= '0;
            corr_cnt_reg   <= '0;
            uncorr_cnt_reg <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_syn_reg     <= syn_next;
                    s1_overall_reg <= overall_next;
                    s1_data_reg    <= s1_data_next;
                end
            end
            if (s2_en) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    data_out_reg   <= data_corr;
                    single_err_reg <= single_next;
                    double_err_reg <= double_next;
                    err_pos_reg    <= err_pos_next;
                end
            end
            corr_cnt_reg   <= corr_cnt_next;
            uncorr_cnt_reg <= uncorr_cnt_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign data_out   = data_out_reg;
    assign single_err = single_err_reg;
    assign double_err = double_err_reg;
    assign err_pos    = err_pos_reg;
    assign corr_cnt   = corr_cnt_reg;
    assign uncorr_cnt = uncorr_cnt_reg;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=4): directed vectors, backpressure,
// counter saturation/clear, mid-stream reset and a randomized stream against an encoder model.
module tb_hamming_secded_decoder;
    import hamming_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  code_in;
    logic        parity_type;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  data_out;
    logic        single_err;
    logic        double_err;
    logic [3:0]  err_pos;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    hamming_secded_decoder #(.DATA_W(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .code_in     (code_in),
        .parity_type (parity_type),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .single_err  (single_err),
        .double_err  (double_err),
        .err_pos     (err_pos),
        .cnt_clr     (cnt_clr),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       s;
        logic       d;
        logic [3:0] pos;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    logic        accepted = 1'b0;
    logic [15:0] exp_corr = '0;
    logic [15:0] exp_uncorr = '0;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_data;
    logic        prev_s;
    logic        prev_d;
    logic [3:0]  prev_pos;
    logic [15:0] c0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference encoder: data into non-power-of-two slots, each parity bit makes its group
    // XOR to pt, then bit 0 makes the whole word XOR to pt.
    function automatic logic [7:0] encode(input logic [3:0] d, input logic pt);
        logic [7:0] c;
        int         k;
        logic       x;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 8; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            x = pt;
            for (int pos = 1; pos < 8; pos++) begin
                if (pos[i] && pos != (1 << i)) x = x ^ c[pos];
            end
            c[1 << i] = x;
        end
        c[0] = pt ^ (^c[7:1]);
        return c;
    endfunction

    function automatic logic [3:0] extract(input logic [7:0] c);
        logic [3:0] d;
        int         k;
        d = '0;
        k = 0;
        for (int pos = 1; pos < 8; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = c[pos];
                k++;
            end
        end
        return d;
    endfunction

    // Random word with 0, 1 or 2 flipped bits; expectation follows from the flip count alone.
    task automatic gen_word();
        logic [3:0] d;
        logic       pt;
        int         nerr;
        int         p1;
        int         p2;
        logic [7:0] c;
        d    = 4'($urandom);
        pt   = ($urandom_range(0, 1) == 1) ? PAR_ODD : PAR_EVEN;
        nerr = $urandom_range(0, 2);
        p1   = $urandom_range(0, 7);
        p2   = (p1 + $urandom_range(1, 7)) % 8;
        c    = encode(d, pt);
        cur_exp = '{data: d, s: 1'b0, d: 1'b0, pos: 4'd0};
        if (nerr >= 1) c = c ^ (8'h01 << p1);
        if (nerr == 1) begin
            cur_exp.s   = 1'b1;
            cur_exp.pos = 4'(p1);
        end
        if (nerr == 2) begin
            c = c ^ (8'h01 << p2);
            cur_exp.d    = 1'b1;
            cur_exp.data = extract(c);
        end
        code_in     = c;
        parity_type = pt;
    endtask

    // One clock: check delivered word and counters, update models, advance to next negedge.
    task automatic step();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            check("unexpected_out", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("out: data=%b s=%b d=%b pos=%0d", data_out, single_err, double_err, err_pos);
                check("data_out", 64'(data_out), 64'(e.data));
                check("single_err", 64'(single_err), 64'(e.s));
                check("double_err", 64'(double_err), 64'(e.d));
                check("err_pos", 64'(err_pos), 64'(e.pos));
            end
        end
        if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(data_out), 64'(prev_data));
            check("stall_flags", 64'({single_err, double_err, err_pos}), 64'({prev_s, prev_d, prev_pos}));
        end
        check("corr_cnt", 64'(corr_cnt), 64'(exp_corr));
        check("uncorr_cnt", 64'(uncorr_cnt), 64'(exp_uncorr));
        if (cnt_clr) begin
            exp_corr   = '0;
            exp_uncorr = '0;
        end else if (out_valid && out_ready && (exp_q.size() >= 0)) begin
            if (single_err && exp_corr != 16'hFFFF) exp_corr++;
            if (double_err && exp_uncorr != 16'hFFFF) exp_uncorr++;
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            exp_q.push_back(cur_exp);
            n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = data_out;
        prev_s     = single_err;
        prev_d     = double_err;
        prev_pos   = err_pos;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_drain(input logic [7:0] c, input logic pt, input logic [3:0] d,
                              input logic s, input logic de, input logic [3:0] p);
        in_valid    = 1'b1;
        code_in     = c;
        parity_type = pt;
        cur_exp     = '{data: d, s: s, d: de, pos: p};
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; code_in = '0; parity_type = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({data_out, single_err, double_err, err_pos}), 64'd0);
        check("rst_counters", 64'({corr_cnt, uncorr_cnt}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Clean word and two-cycle latency.
        in_valid = 1'b1; code_in = 8'hAA; parity_type = PAR_EVEN;
        cur_exp = '{data: 4'b1011, s: 1'b0, d: 1'b0, pos: 4'd0};
        step();
        in_valid = 1'b0;
        check("latency_cycle1", 64'(out_valid), 64'd0);
        step();
        check("latency_cycle2", 64'(out_valid), 64'd1);
        step();
        step();

        c0 = exp_corr;
        send_drain(8'h8A, PAR_EVEN, 4'b1011, 1'b1, 1'b0, 4'd5);
        check("corr_inc", 64'(corr_cnt), 64'(c0 + 16'd1));
        c0 = exp_uncorr;
        send_drain(8'h88, PAR_EVEN, 4'b1001, 1'b0, 1'b1, 4'd0);
        check("uncorr_inc", 64'(uncorr_cnt), 64'(c0 + 16'd1));
        send_drain(8'hBC, PAR_ODD, 4'b1011, 1'b0, 1'b0, 4'd0);
        send_drain(8'hAB, PAR_EVEN, 4'b1011, 1'b1, 1'b0, 4'd0);

        // Backpressure: six words offered back to back, out_ready low for four cycles.
        out_ready = 1'b0;
        accepted  = 1'b0;
        begin
            int nw;
            nw = 0;
            for (int cyc = 0; cyc < 40 && (nw < 6 || in_valid || exp_q.size() != 0); cyc++) begin
                if (cyc == 4) out_ready = 1'b1;
                if (!in_valid || accepted) begin
                    if (nw < 6) begin
                        gen_word();
                        in_valid = 1'b1;
                        nw++;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (cyc < 4) begin
                    #1;
                    check("bp_in_ready", 64'(in_ready), 64'(cyc < 2));
                end
                step();
            end
            check("bp_all_out", 64'(exp_q.size()), 64'd0);
        end
        in_valid = 1'b0;

        // Saturation from a preset all-ones counter.
        force dut.corr_cnt_reg = 16'hFFFF;
        exp_corr = 16'hFFFF;
        step();
        release dut.corr_cnt_reg;
        step();
        send_drain(8'h8A, PAR_EVEN, 4'b1011, 1'b1, 1'b0, 4'd5);
        check("corr_saturate", 64'(corr_cnt), 64'hFFFF);

        // Clear wins over a same-cycle increment.
        in_valid = 1'b1; code_in = 8'h8A; parity_type = PAR_EVEN;
        cur_exp = '{data: 4'b1011, s: 1'b1, d: 1'b0, pos: 4'd5};
        step();
        in_valid = 1'b0;
        step();
        check("clr_setup_valid", 64'(out_valid && single_err), 64'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_priority", 64'(corr_cnt), 64'd0);
        step();

        // Randomized stream with random backpressure and occasional clears.
        n_acc = 0;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 3000 && n_acc < 300; cyc++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 4) != 0);
                if (in_valid) gen_word();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            step();
        end
        check("rand_accepted", 64'(n_acc), 64'd300);
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Mid-stream reset: words in flight must vanish.
        send_drain(8'h8A, PAR_EVEN, 4'b1011, 1'b1, 1'b0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            gen_word();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_counters", 64'({corr_cnt, uncorr_cnt}), 64'd0);
        check("midrst_outputs", 64'({data_out, single_err, double_err, err_pos}), 64'd0);
        exp_q.delete();
        exp_corr = '0; exp_uncorr = '0; prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("postrst_no_stale", 64'(out_valid), 64'd0);
            check("postrst_in_ready", 64'(in_ready), 64'd1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
